// File: rtl/freq_sort_param.sv
// Frequency gather front end: sums per-symbol lane counts, pushes leaf frames
// into a select network, then drains the returned minima into banked RAM.
module freq_sort_param #(
  parameter int NSYM  = 256,
  parameter int NCH   = 4,
  parameter int FW    = 18,
  parameter int SW    = 27,
  parameter int NBANK = 2,
  localparam int AW  = $clog2(NSYM),
  localparam int BW  = AW - $clog2(NBANK),
  localparam int NW  = AW + 1,
  localparam int FRW = NW + SW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              skip_zero,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       leaf_count,
  output logic              sat,
  output logic              freq_oe,
  output logic [AW-1:0]     freq_addr,
  input  logic [NCH*FW-1:0] freq_value,
  output logic              net_wr,
  output logic [FRW-1:0]    net_in,
  input  logic [FRW-1:0]    net_min,
  input  logic              net_valid,
  output logic [NBANK-1:0]  bank_we,
  output logic [BW-1:0]     bank_addr,
  output logic [FRW-1:0]    bank_din
);

  localparam int LW = FW + $clog2(NCH);
  localparam int XW = ((SW > LW) ? SW : LW) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic               skip_q, skip_d;
  logic               freq_oe_q, freq_oe_d;
  logic [AW-1:0]      freq_addr_q, freq_addr_d;
  logic               rd_vld_q, rd_vld_d;
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic [AW:0]        leaf_q, leaf_d;
  logic [AW:0]        out_cnt_q, out_cnt_d;
  logic               sat_q, sat_d;
  logic               net_wr_q, net_wr_d;
  logic [FRW-1:0]     net_in_q, net_in_d;
  logic [NBANK-1:0]   bank_we_q, bank_we_d;
  logic [BW-1:0]      bank_addr_q, bank_addr_d;
  logic [FRW-1:0]     bank_din_q, bank_din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               start_edge;
  logic [XW-1:0]      sum_full;
  logic               sum_ovf;
  logic [SW-1:0]      sum_sat;
  logic               push;

  always_comb begin
    start_d     = start;
    start_edge  = start & ~start_q;
    state_d     = state_q;
    skip_d      = skip_q;
    freq_oe_d   = freq_oe_q;
    freq_addr_d = freq_addr_q;
    leaf_d      = leaf_q;
    out_cnt_d   = out_cnt_q;
    sat_d       = sat_q;
    net_wr_d    = 1'b0;
    net_in_d    = net_in_q;
    bank_we_d   = '0;
    bank_addr_d = bank_addr_q;
    bank_din_d  = bank_din_q;
    rd_vld_d    = freq_oe_q;
    rd_addr_d   = freq_addr_q;

    sum_full = '0;
    for (int i = 0; i < NCH; i++) begin
      sum_full = sum_full + XW'(freq_value[i*FW +: FW]);
    end
    sum_ovf = sum_full > XW'({SW{1'b1}});
    sum_sat = sum_ovf ? {SW{1'b1}} : sum_full[SW-1:0];
    push    = rd_vld_q && !(skip_q && (sum_sat == '0));

    if (rd_vld_q && sum_ovf) sat_d = 1'b1;
    if (push) begin
      net_wr_d = 1'b1;
      net_in_d = {1'b0, rd_addr_q, sum_sat};
      leaf_d   = leaf_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d     = S_READ;
          skip_d      = skip_zero;
          freq_oe_d   = 1'b1;
          freq_addr_d = AW'(NSYM - 1);
          leaf_d      = '0;
          sat_d       = 1'b0;
          out_cnt_d   = '0;
        end
      end
      S_READ: begin
        if (freq_addr_q == '0) begin
          state_d     = S_FLUSH;
          freq_oe_d   = 1'b0;
          freq_addr_d = AW'(NSYM - 1);
        end else begin
          freq_addr_d = freq_addr_q - 1'b1;
        end
      end
      S_FLUSH: begin
        // leaf_d already counts the final datum consumed this cycle
        state_d = (leaf_d == '0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        if (net_valid) begin
          bank_we_d   = NBANK'(1) << (out_cnt_q % NBANK);
          bank_addr_d = BW'(out_cnt_q / NBANK);
          bank_din_d  = net_min;
          out_cnt_d   = out_cnt_q + 1'b1;
          if (out_cnt_d == leaf_q) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_READ) || (state_d == S_FLUSH) ||
             (state_d == S_COLLECT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      skip_q      <= 1'b0;
      freq_oe_q   <= 1'b0;
      freq_addr_q <= AW'(NSYM - 1);
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      leaf_q      <= '0;
      out_cnt_q   <= '0;
      sat_q       <= 1'b0;
      net_wr_q    <= 1'b0;
      net_in_q    <= '0;
      bank_we_q   <= '0;
      bank_addr_q <= '0;
      bank_din_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      skip_q      <= skip_d;
      freq_oe_q   <= freq_oe_d;
      freq_addr_q <= freq_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      leaf_q      <= leaf_d;
      out_cnt_q   <= out_cnt_d;
      sat_q       <= sat_d;
      net_wr_q    <= net_wr_d;
      net_in_q    <= net_in_d;
      bank_we_q   <= bank_we_d;
      bank_addr_q <= bank_addr_d;
      bank_din_q  <= bank_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign leaf_count = leaf_q;
  assign sat        = sat_q;
  assign freq_oe    = freq_oe_q;
  assign freq_addr  = freq_addr_q;
  assign net_wr     = net_wr_q;
  assign net_in     = net_in_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_din   = bank_din_q;

endmodule

// File: tb/tb_freq_sort_param.sv
// Scoreboard bench for freq_sort_param: default build plus a small
// 16-symbol, 4-bank, 27-bit-lane build.
module tb_freq_sort_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        start0 = 1'b0, skip0 = 1'b0, nvld0 = 1'b0;
  logic        busy0, done0, sat0, oe0, nwr0;
  logic [8:0]  leaf0;
  logic [7:0]  fa0;
  logic [71:0] fv0;
  logic [35:0] nin0, din0;
  logic [35:0] nmin0 = '0;
  logic [1:0]  we0;
  logic [6:0]  ba0;

  logic         start1 = 1'b0, skip1 = 1'b0, nvld1 = 1'b0;
  logic         busy1, done1, sat1, oe1, nwr1;
  logic [4:0]   leaf1;
  logic [3:0]   fa1;
  logic [107:0] fv1;
  logic [31:0]  nin1, din1;
  logic [31:0]  nmin1 = '0;
  logic [3:0]   we1;
  logic [1:0]   ba1;

  logic [71:0]  ram0 [256];
  logic [107:0] ram1 [16];

  logic [35:0] xp0[$];
  logic [44:0] xw0[$];
  logic [31:0] xp1[$];
  logic [37:0] xw1[$];

  int nvec = 0;
  int nerr = 0;
  int bc0_0 = 0, bc0_1 = 0, wc1 = 0;

  always @(posedge clk) if (oe0) fv0 <= ram0[fa0];
  always @(posedge clk) if (oe1) fv1 <= ram1[fa1];

  freq_sort_param u0 (
    .clk(clk), .rst(rst), .start(start0), .skip_zero(skip0),
    .busy(busy0), .done(done0), .leaf_count(leaf0), .sat(sat0),
    .freq_oe(oe0), .freq_addr(fa0), .freq_value(fv0),
    .net_wr(nwr0), .net_in(nin0), .net_min(nmin0), .net_valid(nvld0),
    .bank_we(we0), .bank_addr(ba0), .bank_din(din0)
  );

  freq_sort_param #(.NSYM(16), .FW(27), .NBANK(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .skip_zero(skip1),
    .busy(busy1), .done(done1), .leaf_count(leaf1), .sat(sat1),
    .freq_oe(oe1), .freq_addr(fa1), .freq_value(fv1),
    .net_wr(nwr1), .net_in(nin1), .net_min(nmin1), .net_valid(nvld1),
    .bank_we(we1), .bank_addr(ba1), .bank_din(din1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nwr0) begin
      if (xp0.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL push0: unexpected frame %h, required none", nin0);
      end else chk("push0", 64'(nin0), 64'(xp0.pop_front()));
    end
    if (we0 != 2'b00) begin
      if (we0[0]) bc0_0++;
      if (we0[1]) bc0_1++;
      if (xw0.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL write0: unexpected we=%b, required none", we0);
      end else chk("write0", 64'({we0, ba0, din0}), 64'(xw0.pop_front()));
    end
    if (nwr1) begin
      if (xp1.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL push1: unexpected frame %h, required none", nin1);
      end else chk("push1", 64'(nin1), 64'(xp1.pop_front()));
    end
    if (we1 != 4'b0000) begin
      wc1++;
      if (xw1.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL write1: unexpected we=%b, required none", we1);
      end else chk("write1", 64'({we1, ba1, din1}), 64'(xw1.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_push(input int d, input int maxc);
    int n;
    n = 0;
    while (((d == 0) ? xp0.size() : xp1.size()) != 0 && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    chk((d == 0) ? "drain_push0" : "drain_push1",
        64'((d == 0) ? xp0.size() : xp1.size()), 64'd0);
  endtask

  task automatic wait_done(input int d, input int maxc);
    int n;
    n = 0;
    while (((d == 0) ? done0 : done1) !== 1'b1 && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk); #1;
    chk((d == 0) ? "done0" : "done1",
        64'((d == 0) ? done0 : done1), 64'd1);
  endtask

  task automatic send0(input int n);
    logic [35:0] v;
    for (int i = 0; i < n; i++) begin
      v = {4'(i), 32'hC0DE_0000 + 32'(i)};
      nvld0 = 1'b1;
      nmin0 = v;
      xw0.push_back({2'(1 << (i % 2)), 7'(i / 2), v});
      tick(1);
    end
    nvld0 = 1'b0;
  endtask

  task automatic send1(input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = 32'h7000_0000 + 32'(i * 3);
      nvld1 = 1'b1;
      nmin1 = v;
      xw1.push_back({4'(1 << (i % 4)), 2'(i / 4), v});
      tick(1);
    end
    nvld1 = 1'b0;
  endtask

  task automatic chk_reset0();
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_sat", 64'(sat0), 64'd0);
    chk("rst_oe", 64'(oe0), 64'd0);
    chk("rst_wr", 64'(nwr0), 64'd0);
    chk("rst_we", 64'(we0), 64'd0);
    chk("rst_addr", 64'(fa0), 64'hFF);
    chk("rst_leaf", 64'(leaf0), 64'd0);
    chk("rst_netin", 64'(nin0), 64'd0);
    chk("rst_din", 64'(din0), 64'd0);
  endtask

  task automatic load_sparse0();
    for (int a = 0; a < 256; a++) ram0[a] = '0;
    ram0[3]   = 72'd5;
    ram0[200] = 72'd7;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [26:0] f;
    for (int a = 0; a < 256; a++) ram0[a] = '0;
    for (int a = 0; a < 16; a++) ram1[a] = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk_reset0();
    chk("rst1_addr", 64'(fa1), 64'hF);
    chk("rst1_busy", 64'(busy1), 64'd0);
    chk("rst1_leaf", 64'(leaf1), 64'd0);
    tick(1);

    // all lanes 1, no skipping, start held high through DONE
    for (int a = 0; a < 256; a++) ram0[a] = {4{18'd1}};
    for (int a = 255; a >= 0; a--) xp0.push_back({1'b0, 8'(a), 27'd4});
    skip0 = 1'b0;
    start0 = 1'b1;
    tick(1);
    @(negedge clk);
    chk("busy_read", 64'(busy0), 64'd1);
    wait_push(0, 400);
    tick(2);
    chk("leaf_256", 64'(leaf0), 64'd256);
    chk("sat_clear", 64'(sat0), 64'd0);
    send0(256);
    wait_done(0, 20);
    chk("bank0_cnt", 64'(bc0_0), 64'd128);
    chk("bank1_cnt", 64'(bc0_1), 64'd128);
    chk("wr_drain0", 64'(xw0.size()), 64'd0);
    tick(5);
    @(negedge clk);
    chk("held_done", 64'(done0), 64'd1);
    chk("held_oe", 64'(oe0), 64'd0);
    start0 = 1'b0;
    tick(2);

    // skip_zero with two nonzero symbols
    load_sparse0();
    xp0.push_back({1'b0, 8'd200, 27'd7});
    xp0.push_back({1'b0, 8'd3, 27'd5});
    skip0 = 1'b1;
    pulse(0);
    tick(4);
    @(negedge clk);
    chk("leaf_clr", 64'(leaf0), 64'd0);
    chk("busy_run2", 64'(busy0), 64'd1);
    chk("done_run2", 64'(done0), 64'd0);
    wait_push(0, 400);
    tick(2);
    chk("leaf_2", 64'(leaf0), 64'd2);
    send0(2);
    wait_done(0, 20);
    chk("wr_drain2", 64'(xw0.size()), 64'd0);
    tick(2);

    // skip_zero with nothing nonzero
    for (int a = 0; a < 256; a++) ram0[a] = '0;
    pulse(0);
    wait_done(0, 400);
    chk("leaf_0", 64'(leaf0), 64'd0);
    chk("no_writes", 64'(bc0_0 + bc0_1), 64'd258);
    tick(2);

    // abort mid-READ with start held, then fresh restart
    load_sparse0();
    start0 = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    start0 = 1'b0;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset0();
    tick(5);
    @(negedge clk);
    chk("no_retrig_oe", 64'(oe0), 64'd0);
    chk("no_retrig_busy", 64'(busy0), 64'd0);
    tick(1);
    xp0.push_back({1'b0, 8'd200, 27'd7});
    xp0.push_back({1'b0, 8'd3, 27'd5});
    pulse(0);
    @(negedge clk);
    chk("restart_addr", 64'(fa0), 64'hFF);
    chk("restart_oe", 64'(oe0), 64'd1);
    @(negedge clk);
    chk("restart_addr2", 64'(fa0), 64'hFE);
    wait_push(0, 400);
    tick(2);
    chk("leaf_restart", 64'(leaf0), 64'd2);
    send0(2);
    wait_done(0, 20);
    chk("wr_drain4", 64'(xw0.size()), 64'd0);

    // small build: saturation, 4-bank rotation, net_valid ignored in READ
    for (int a = 0; a < 16; a++)
      ram1[a] = (a == 0) ? {4{27'h7FF_FFFF}} : 108'(a + 1);
    for (int a = 15; a >= 0; a--) begin
      f = (a == 0) ? 27'h7FF_FFFF : 27'(a + 1);
      xp1.push_back({1'b0, 4'(a), f});
    end
    skip1 = 1'b0;
    pulse(1);
    tick(2);
    nvld1 = 1'b1;
    nmin1 = 32'hDEAD_BEEF;
    tick(4);
    nvld1 = 1'b0;
    wait_push(1, 60);
    tick(2);
    chk("sat1", 64'(sat1), 64'd1);
    chk("leaf1_16", 64'(leaf1), 64'd16);
    send1(16);
    wait_done(1, 20);
    chk("wr_drain1", 64'(xw1.size()), 64'd0);
    chk("wr_cnt1", 64'(wc1), 64'd16);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/freq_sort_param.md
FREQ_SORT_PARAM -- requirements
Module: freq_sort_param

Interface
REQ-001 Parameter NSYM, default 256, meaning: symbol count; power of two, at most 512; AW = log2(NSYM).
REQ-002 Parameter NCH, default 4, meaning: number of frequency RAM lanes summed per symbol.
REQ-003 Parameter FW, default 18, meaning: width of one lane's frequency value.
REQ-004 Parameter SW, default 27, meaning: summed frequency width; SW >= FW.
REQ-005 Parameter NBANK, default 2, meaning: output RAM banks, power of two >= 1; BW = AW - log2(NBANK); NW = AW+1; FRW = NW+SW.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request; only a 0->1 transition (registered previous value) is acted on.
REQ-009 skip_zero  in  1  mode; sampled on the accepted start edge.
REQ-010 busy  out  1  high in READ, FLUSH and COLLECT.
REQ-011 done  out  1  level; high in DONE.
REQ-012 leaf_count  out  AW+1  frames pushed to the network in the current or last run.
REQ-013 sat  out  1  sticky per run; set if any summed frequency saturated.
REQ-014 freq_oe  out  1  frequency RAM read enable.
REQ-015 freq_addr  out  AW  frequency RAM address, shared by all lanes.
REQ-016 freq_value  in  NCH*FW  lane i in bits [i*FW +: FW]; valid one cycle after freq_addr/freq_oe.
REQ-017 net_wr  out  1  push strobe to the select network.
REQ-018 net_in  out  FRW  pushed frame {1'b0, symbol[AW-1:0], freq[SW-1:0]}.
REQ-019 net_min  in  FRW  minimum frame returned by the network.
REQ-020 net_valid  in  1  net_min valid this cycle.
REQ-021 bank_we  out  NBANK  one-hot write enable per bank.
REQ-022 bank_addr  out  BW  write address, shared by all banks.
REQ-023 bank_din  out  FRW  write data, equal to net_min.

Function
REQ-024 States SHALL be IDLE, READ, FLUSH, COLLECT and DONE.
REQ-025 IDLE or DONE plus a start edge -> READ; a start edge in any other state SHALL be ignored.
REQ-026 READ SHALL last exactly NSYM cycles, with freq_oe=1 and freq_addr counting NSYM-1 down to 0; after that, go to FLUSH.
REQ-027 FLUSH SHALL last one cycle to consume the last read datum, then go to COLLECT, or to DONE if leaf_count=0.
REQ-028 Each returned datum (read address a, 1-cycle latency) SHALL be summed as the zero-extended sum of all NCH lanes; a sum exceeding 2^SW-1 SHALL saturate to 2^SW-1 and set sat.
REQ-029 net_wr SHALL pulse for the datum of address a with net_in={0,a,sum}, unless skip_zero=1 and sum=0; each push SHALL increment leaf_count.
REQ-030 COLLECT: each net_valid cycle SHALL assert bank_we[k] with k=out_cnt mod NBANK, bank_addr=out_cnt/NBANK and bank_din=net_min, then increment out_cnt.
REQ-031 The net_valid cycle that makes out_cnt reach leaf_count SHALL still write, and the next state SHALL be DONE.
REQ-032 net_valid outside COLLECT SHALL be ignored, with no writes.
REQ-033 A start edge accepted in DONE SHALL clear leaf_count, sat and out_cnt in the cycle READ is entered.
REQ-034 The start edge detector SHALL run in all states, so start held high does not retrigger.

Reset
REQ-035 On rst: state=IDLE; busy, done, sat, freq_oe, net_wr and bank_we = 0; freq_addr=NSYM-1; leaf_count=0; net_in and bank_din = 0; start history = 0.
REQ-036 rst asserted mid-run SHALL abort the run at the next edge with no further pushes or writes; a run begins again only on a fresh start edge.

Verification
REQ-037 Defaults, skip_zero=0, all lanes = 1 -> 256 pushes each with freq=4, first net_in={0,8'hFF,27'd4}; leaf_count=256; after 256 net_valid cycles, banks 0 and 1 each receive 128 writes; done=1.
REQ-038 skip_zero=1, only symbols 3 and 200 nonzero (lane0=5, lane0=7) -> exactly 2 pushes, 200 first; leaf_count=2; the second net_valid writes bank 1 at address 0, then DONE.
REQ-039 skip_zero=1, all zero -> no pushes, FLUSH->DONE, leaf_count=0, bank_we never asserted.
REQ-040 FW=27, all four lanes = 2^27-1 at symbol 0 -> net_in freq=27'h7FFFFFF, sat=1.
REQ-041 start held high through DONE, then rst at READ cycle 10 -> no retrigger; after reset all outputs equal their reset values, and the next start edge restarts from freq_addr=NSYM-1.
REQ-042 NBANK=4, NSYM=16 -> writes rotate through banks 0,1,2,3 with bank_addr 0..3; net_valid pulsed during READ is ignored.
